// File: rtl/bcd_scan_display.sv
// bcd_scan_display: converts an 8-bit unsigned result to three BCD digits with a
// sequential double-dabble FSM, holds them in an atomically updated buffer, and
// scans them onto a common-anode 4-digit seven-segment display.
module bcd_scan_display #(
  parameter int REFRESH_DIV   = 50000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       busy
);

  localparam int             PW   = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0]  PMAX = PW'(REFRESH_DIV - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  logic [1:0]    r_state;
  logic          r_pending;
  logic [7:0]    r_lastValue;
  logic [7:0]    r_captured;
  logic [7:0]    r_bin;
  logic [11:0]   r_bcd;
  logic [2:0]    r_shiftCnt;
  logic          r_busy;
  logic [3:0]    r_dispHund;
  logic [3:0]    r_dispTens;
  logic [3:0]    r_dispOnes;
  logic [PW-1:0] r_prescale;
  logic [1:0]    r_scanIdx;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;

  logic [11:0]   w_adj;
  logic [3:0]    w_digit;
  logic [3:0]    w_anSel;
  logic          w_blank;
  logic [6:0]    w_segCode;

  // Double-dabble correction: add 3 to any BCD nibble that would overflow on shift.
  always_comb begin
    w_adj = r_bcd;
    if (r_bcd[3:0] >= 4'd5)  w_adj[3:0]  = r_bcd[3:0]  + 4'd3;
    if (r_bcd[7:4] >= 4'd5)  w_adj[7:4]  = r_bcd[7:4]  + 4'd3;
    if (r_bcd[11:8] >= 4'd5) w_adj[11:8] = r_bcd[11:8] + 4'd3;
  end

  // Conversion FSM: capture in IDLE, eight shifts, then commit all digits in one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pending   <= 1'b1;
      r_lastValue <= 8'd0;
      r_captured  <= 8'd0;
      r_bin       <= 8'd0;
      r_bcd       <= 12'd0;
      r_shiftCnt  <= 3'd0;
      r_busy      <= 1'b0;
      r_dispHund  <= 4'd0;
      r_dispTens  <= 4'd0;
      r_dispOnes  <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_pending || (value != r_lastValue)) begin
            r_captured <= value;
            r_bin      <= value;
            r_bcd      <= 12'd0;
            r_shiftCnt <= 3'd0;
            r_busy     <= 1'b1;
            r_pending  <= 1'b0;
            r_state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
          r_shiftCnt     <= r_shiftCnt + 3'd1;
          if (r_shiftCnt == 3'd7) r_state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          r_dispHund  <= r_bcd[11:8];
          r_dispTens  <= r_bcd[7:4];
          r_dispOnes  <= r_bcd[3:0];
          r_lastValue <= r_captured;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Refresh prescaler and digit scan index (ones -> tens -> hundreds -> ones).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prescale <= '0;
      r_scanIdx  <= 2'd0;
    end else if (r_prescale == PMAX) begin
      r_prescale <= '0;
      r_scanIdx  <= (r_scanIdx == 2'd2) ? 2'd0 : r_scanIdx + 2'd1;
    end else begin
      r_prescale <= r_prescale + 1'b1;
    end
  end

  // Pick the active digit, its anode, and whether leading-zero blanking hides it.
  always_comb begin
    w_digit = r_dispOnes;
    w_anSel = 4'b1110;
    w_blank = 1'b0;
    case (r_scanIdx)
      2'd1: begin
        w_digit = r_dispTens;
        w_anSel = 4'b1101;
        w_blank = BLANK_LEADING && (r_dispHund == 4'd0) && (r_dispTens == 4'd0);
      end
      2'd2: begin
        w_digit = r_dispHund;
        w_anSel = 4'b1011;
        w_blank = BLANK_LEADING && (r_dispHund == 4'd0);
      end
      default: begin
        w_digit = r_dispOnes;
        w_anSel = 4'b1110;
        w_blank = 1'b0;
      end
    endcase
  end

  // Active-low segment decode {g,f,e,d,c,b,a}; non-decimal nibbles stay dark.
  always_comb begin
    w_segCode = 7'b1111111;
    case (w_digit)
      4'd0: w_segCode = 7'b1000000;
      4'd1: w_segCode = 7'b1111001;
      4'd2: w_segCode = 7'b0100100;
      4'd3: w_segCode = 7'b0110000;
      4'd4: w_segCode = 7'b0011001;
      4'd5: w_segCode = 7'b0010010;
      4'd6: w_segCode = 7'b0000010;
      4'd7: w_segCode = 7'b1111000;
      4'd8: w_segCode = 7'b0000000;
      4'd9: w_segCode = 7'b0010000;
      default: w_segCode = 7'b1111111;
    endcase
  end

  // Register the display drive so anodes and segments change together, glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
    end else if (w_blank) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
    end else begin
      r_an  <= w_anSel;
      r_seg <= w_segCode;
    end
  end

  assign an   = r_an;
  assign seg  = r_seg;
  assign busy = r_busy;

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb_bcd_scan_display: directed checks of conversion latency, atomic buffer update,
// scan timing and leading-zero blanking on two differently parameterised instances.
module tb_bcd_scan_display;

  logic       clk;
  logic       reset;
  logic [7:0] value;
  logic [3:0] anA, anB;
  logic [6:0] segA, segB;
  logic       busyA, busyB;
  int         cyc;
  int         checkCount;
  int         passCount;

  // Instance A: fast refresh with leading-zero blanking.
  bcd_scan_display #(.REFRESH_DIV(2), .BLANK_LEADING(1'b1)) u_dutA (
    .clk(clk), .reset(reset), .value(value), .an(anA), .seg(segA), .busy(busyA)
  );

  // Instance B: slower refresh, all three digits always shown.
  bcd_scan_display #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) u_dutB (
    .clk(clk), .reset(reset), .value(value), .an(anB), .seg(segB), .busy(busyB)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Clock edges since reset release, used to predict the scan slot.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic logic [6:0] segCode(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected {an,seg} a cycle after edge 'cycle' for a given refresh divider.
  function automatic logic [10:0] expScan(input int div, input bit blank, input int cycle,
                                          input logic [3:0] h, input logic [3:0] t,
                                          input logic [3:0] o);
    int         slot;
    logic [3:0] d;
    logic [3:0] a;
    bit         off;
    slot = ((cycle - 1) / div) % 3;
    d = o; a = 4'b1110; off = 1'b0;
    if (slot == 1) begin
      d = t; a = 4'b1101; off = blank && (h == 4'd0) && (t == 4'd0);
    end else if (slot == 2) begin
      d = h; a = 4'b1011; off = blank && (h == 4'd0);
    end
    return off ? 11'h7FF : {a, segCode(d)};
  endfunction

  // Single comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic applyStimulus(input logic [7:0] v);
    value = v;
  endtask

  // Advance one cycle and check busy plus the scanned digit on both instances.
  task automatic stepCheck(input logic expBusy, input logic [3:0] h, input logic [3:0] t,
                           input logic [3:0] o);
    @(negedge clk);
    checkOutput("busyA", {31'd0, busyA}, {31'd0, expBusy});
    checkOutput("busyB", {31'd0, busyB}, {31'd0, expBusy});
    checkOutput("scanA", {21'd0, anA, segA}, {21'd0, expScan(2, 1'b1, cyc, h, t, o)});
    checkOutput("scanB", {21'd0, anB, segB}, {21'd0, expScan(4, 1'b0, cyc, h, t, o)});
    checkOutput("anA_onehot", {31'd0, ($countones(~anA) <= 1) && anA[3]}, 32'd1);
    checkOutput("anB_onehot", {31'd0, ($countones(~anB) <= 1) && anB[3]}, 32'd1);
  endtask

  task automatic holdCheck(input int n, input logic [3:0] h, input logic [3:0] t,
                           input logic [3:0] o);
    repeat (n) stepCheck(1'b0, h, t, o);
  endtask

  // Full conversion: old digits stay up through commit, new digits the cycle after.
  task automatic convert(input logic [7:0] v, input logic [3:0] oh, input logic [3:0] ot,
                         input logic [3:0] oo, input logic [3:0] nh, input logic [3:0] nt,
                         input logic [3:0] no);
    applyStimulus(v);
    repeat (9) stepCheck(1'b1, oh, ot, oo);
    stepCheck(1'b0, oh, ot, oo);
    holdCheck(12, nh, nt, no);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_anA"},   {28'd0, anA},   32'hF);
    checkOutput({tag, "_segA"},  {25'd0, segA},  32'h7F);
    checkOutput({tag, "_busyA"}, {31'd0, busyA}, 32'd0);
    checkOutput({tag, "_anB"},   {28'd0, anB},   32'hF);
    checkOutput({tag, "_segB"},  {25'd0, segB},  32'h7F);
    checkOutput({tag, "_busyB"}, {31'd0, busyB}, 32'd0);
  endtask

  // Directed sequence.
  initial begin
    checkCount = 0;
    passCount  = 0;
    reset = 1'b1;
    value = 8'd255;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    reset = 1'b0;

    // 255 converted straight out of reset; scan held for two full rotations.
    convert(8'd255, 4'd0, 4'd0, 4'd0, 4'd2, 4'd5, 4'd5);
    holdCheck(12, 4'd2, 4'd5, 4'd5);

    // Leading-zero blanking vs. no blanking.
    convert(8'd7, 4'd2, 4'd5, 4'd5, 4'd0, 4'd0, 4'd7);

    // Interior zero is shown; buffer swaps atomically.
    convert(8'd100, 4'd0, 4'd0, 4'd7, 4'd1, 4'd0, 4'd0);
    convert(8'd205, 4'd1, 4'd0, 4'd0, 4'd2, 4'd0, 4'd5);

    // Value changes mid-conversion: 12 completes, 99 follows after one idle cycle.
    applyStimulus(8'd12);
    repeat (4) stepCheck(1'b1, 4'd2, 4'd0, 4'd5);
    applyStimulus(8'd99);
    repeat (5) stepCheck(1'b1, 4'd2, 4'd0, 4'd5);
    stepCheck(1'b0, 4'd2, 4'd0, 4'd5);
    repeat (9) stepCheck(1'b1, 4'd0, 4'd1, 4'd2);
    stepCheck(1'b0, 4'd0, 4'd1, 4'd2);
    holdCheck(12, 4'd0, 4'd9, 4'd9);

    // Remaining digit codes.
    convert(8'd146, 4'd0, 4'd9, 4'd9, 4'd1, 4'd4, 4'd6);
    convert(8'd38, 4'd1, 4'd4, 4'd6, 4'd0, 4'd3, 4'd8);

    // Reset during the shift phase aborts and forces reconversion.
    applyStimulus(8'd200);
    repeat (5) stepCheck(1'b1, 4'd0, 4'd3, 4'd8);
    #2 reset = 1'b1;
    #1 checkResetOutputs("midreset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    convert(8'd200, 4'd0, 4'd0, 4'd0, 4'd2, 4'd0, 4'd0);

    // Zero: only the ones digit lit on the blanking instance.
    convert(8'd0, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
